// File: rtl/mux_nto1_ctx_cfg.sv
// mux_nto1_ctx_cfg: N-to-1 CGRA routing mux whose per-context selects come from a serial config chain.
// Define MUX_CTX_OUT_REG_EN to register out. The context port is named context_o because context is a reserved word.
module mux_nto1_ctx_cfg #(
  parameter int WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_CONTEXTS = 1,
  localparam int SEL_W = $clog2(NUM_INPUTS),
  localparam int CTX_W = NUM_CONTEXTS > 1 ? $clog2(NUM_CONTEXTS) : 1,
  localparam int CFG_W = NUM_CONTEXTS * SEL_W
) (
  input  logic                        CGRA_Clock,
  input  logic                        CGRA_Reset,
  input  logic                        CGRA_Enable,
  input  logic                        Config_Enable,
  input  logic                        ConfigIn,
  output logic                        ConfigOut,
  input  logic [NUM_INPUTS*WIDTH-1:0] in,
  output logic [WIDTH-1:0]            out,
  output logic [CTX_W-1:0]            context_o
);
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CTX_W-1:0] ctx_q, ctx_d;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] mux_val;
  logic             run;
  always_comb begin
    run = CGRA_Enable && !Config_Enable;
    cfg_d = Config_Enable ? CFG_W'({cfg_q, ConfigIn}) : cfg_q;
    ctx_d = !run ? ctx_q : (ctx_q == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : ctx_q + 1'b1;
    sel = cfg_q[int'(ctx_q)*SEL_W +: SEL_W];
    mux_val = '0;
    // Unmatched selects (>= NUM_INPUTS) leave the zero default in place.
    for (int k = 0; k < NUM_INPUTS; k++)
      if (int'(sel) == k) mux_val = in[k*WIDTH +: WIDTH];
  end
  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      cfg_q <= '0;
      ctx_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      ctx_q <= ctx_d;
    end
  end
`ifdef MUX_CTX_OUT_REG_EN
  logic [WIDTH-1:0] out_q;
  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) out_q <= '0;
    else if (run) out_q <= mux_val;
  end
  assign out = out_q;
`else
  assign out = CGRA_Reset ? '0 : mux_val;
`endif
  assign ConfigOut = cfg_q[CFG_W-1];
  assign context_o = ctx_q;
endmodule

// File: tb/tb_mux_nto1_ctx_cfg.sv
// tb_mux_nto1_ctx_cfg: directed checks of the context-switched config mux, in both output modes.
module tb_mux_nto1_ctx_cfg;
  logic         clk = 1'b0;
  logic         rst, en, ce, cin, en6, ce6, cin6;
  logic [191:0] in_a;
  logic [63:0]  in6;
  logic [31:0]  out_a, out6;
  logic [1:0]   ctx_a;
  logic [0:0]   ctx6;
  logic         cout_a, cout6;
  int           total = 0, bad = 0;

  always #5 clk = ~clk;

  mux_nto1_ctx_cfg #(.WIDTH(32), .NUM_INPUTS(6), .NUM_CONTEXTS(4)) u_dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .CGRA_Enable(en), .Config_Enable(ce),
    .ConfigIn(cin), .ConfigOut(cout_a), .in(in_a), .out(out_a), .context_o(ctx_a));

  mux_nto1_ctx_cfg #(.WIDTH(32), .NUM_INPUTS(2), .NUM_CONTEXTS(1)) u_dut6 (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .CGRA_Enable(en6), .Config_Enable(ce6),
    .ConfigIn(cin6), .ConfigOut(cout6), .in(in6), .out(out6), .context_o(ctx6));

`ifdef MUX_CTX_OUT_REG_EN
  int exp2[5] = '{1, 2, 3, 5, 1};
  int exp4[3] = '{2, 2, 2};
  int exp3[5] = '{-1, 4, 4, 4, -1};
  int pre4    = 2;
`else
  int exp2[5] = '{2, 3, 5, 1, 2};
  int exp4[3] = '{-1, 5, 2};
  int exp3[5] = '{4, 4, 4, -1, 4};
  int pre4    = 3;
`endif
  int ctx2[5] = '{1, 2, 3, 0, 1};
  int ctx3[5] = '{1, 2, 3, 0, 1};
  int co4[3]  = '{1, 0, 1};

  function automatic logic [31:0] iv(int k);
    return k < 0 ? 32'h0 : 32'h1000_0000 + 32'(k);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift12(logic [11:0] v);
    ce = 1'b1;
    en = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      cin = v[i];
      step();
    end
    ce = 1'b0;
  endtask

  task automatic run_edge();
    en = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ce = 1'b1; cin = 1'b1;
    en6 = 1'b0; ce6 = 1'b0; cin6 = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in6 = 64'h2000_0001_2000_0000;
    step();
    step();
    chk("rst_out", out_a, 32'h0);
    chk("rst_ctx", 32'(ctx_a), 32'h0);
    chk("rst_cout", 32'(cout_a), 32'h0);
    for (int k = 0; k < 6; k++) in_a[k*32 +: 32] = iv(k);
    rst = 1'b0; en = 1'b0; ce = 1'b0; cin = 1'b0;
    step();
    run_edge();
    chk("first_en_out", out_a, iv(0));
    en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    shift12(12'b101_011_010_001);
    chk("load_cout", 32'(cout_a), 32'h1);
    chk("load_ctx_hold", 32'(ctx_a), 32'h0);
    for (int i = 0; i < 5; i++) begin
      run_edge();
      chk($sformatf("run_out%0d", i), out_a, iv(exp2[i]));
      chk($sformatf("run_ctx%0d", i), 32'(ctx_a), 32'(ctx2[i]));
    end
    run_edge();
    chk("pre_recfg_ctx", 32'(ctx_a), 32'h2);
    chk("pre_recfg_out", out_a, iv(pre4));
    ce = 1'b1; en = 1'b1; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("recfg_cout%0d", i), 32'(cout_a), 32'(co4[i]));
      step();
      chk($sformatf("recfg_ctx%0d", i), 32'(ctx_a), 32'h2);
      chk($sformatf("recfg_out%0d", i), out_a, iv(exp4[i]));
    end
    ce = 1'b0;
    shift12(12'b101_011_010_001);
    run_edge();
    run_edge();
    rst = 1'b1;
    step();
    chk("midrst_ctx", 32'(ctx_a), 32'h0);
    chk("midrst_out", out_a, 32'h0);
    chk("midrst_cout", 32'(cout_a), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_edge();
      chk($sformatf("postrst_out%0d", i), out_a, iv(0));
    end
    en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    shift12(12'b100_100_100_111);
    for (int i = 0; i < 5; i++) begin
      run_edge();
      chk($sformatf("oor_out%0d", i), out_a, iv(exp3[i]));
      chk($sformatf("oor_ctx%0d", i), 32'(ctx_a), 32'(ctx3[i]));
    end
    en = 1'b0;
    ce6 = 1'b1; cin6 = 1'b1;
    step();
    ce6 = 1'b0;
    chk("c1_cout", 32'(cout6), 32'h1);
    en6 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("c1_out1_%0d", i), out6, 32'h2000_0001);
      chk($sformatf("c1_ctx_%0d", i), 32'(ctx6), 32'h0);
    end
    en6 = 1'b0; ce6 = 1'b1; cin6 = 1'b0;
    step();
    ce6 = 1'b0; en6 = 1'b1;
    step();
    chk("c1_cout0", 32'(cout6), 32'h0);
    chk("c1_out0", out6, 32'h2000_0000);
    en6 = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_nto1_ctx_cfg.md
Name: mux_nto1_ctx_cfg

Overview:
Parametrised N-to-1 datapath multiplexer for the CGRA fabric. It supersedes the fixed 4-input, 32-bit mux. The select value comes from an internal configuration register loaded over the serial config chain. The register holds one select per context, and an internal context counter steps through the contexts while the array runs, so one routing mux can serve time-multiplexed schedules.

Parameters:
- WIDTH, 32, data width of each input and of out.
- NUM_INPUTS, 4, number of data inputs; must be ≥ 2.
- NUM_CONTEXTS, 1, number of stored selects; must be ≥ 1.
- SEL_W, derived, ceil(log2(NUM_INPUTS)).
- CTX_W, derived, max(1, ceil(log2(NUM_CONTEXTS))).
- CFG_W, derived, NUM_CONTEXTS*SEL_W, length of the config chain segment.

Ports:
- CGRA_Clock  in  1  only clock; all state updates on its rising edge.
- CGRA_Reset  in  1  synchronous, active-high reset.
- CGRA_Enable  in  1  run enable; advances the context, and the output register if built in.
- Config_Enable  in  1  when high, the config register shifts by one bit per cycle.
- ConfigIn  in  1  serial config data in.
- ConfigOut  out  1  serial config data out; equals cfg[CFG_W-1].
- in  in  NUM_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out  out  WIDTH  selected data.
- context  out  CTX_W  current context index.

Behaviour:
- Config register cfg[CFG_W-1:0]: select for context c = cfg[c*SEL_W +: SEL_W].
- Config shift, when Config_Enable=1: cfg <= {cfg[CFG_W-2:0], ConfigIn}. Bits are loaded MSB first. ConfigOut = cfg[CFG_W-1], taken from the register. Chain latency is CFG_W cycles.
- Context counter:
  - Advances when CGRA_Enable=1 and Config_Enable=0.
  - Wraps from NUM_CONTEXTS-1 to 0.
  - Stays at 0 when NUM_CONTEXTS=1.
- Priority: CGRA_Reset > Config_Enable > CGRA_Enable. While Config_Enable=1, the counter and any output register hold and cfg shifts.
- Select decode: sel = cfg[context*SEL_W +: SEL_W]. If sel ≥ NUM_INPUTS, out = 0 (defined; never X).
- Reset: cfg = 0, context = 0, out = 0, ConfigOut = 0. A reset in the middle of a shift discards the partial config. After reset every context selects in0.
- The counter and cfg update on the same edge when both are permitted. Because config wins, that situation does not arise.

Optional Feature:
MUX_CTX_OUT_REG_EN.
- Defined:
  - out is a register, reset to 0.
  - On an edge with CGRA_Enable=1 and Config_Enable=0, out <= in[sel(context before the edge)] and the context advances on the same edge.
  - Latency is 1 cycle. Otherwise out holds.
- Undefined: out is combinational from the current context's select, with latency 0.

Test Plan:
Setup for tests 1–5: WIDTH=32, NUM_INPUTS=6, NUM_CONTEXTS=4 (SEL_W=3, CFG_W=12); in[k] = 32'h1000_0000+k; MUX_CTX_OUT_REG_EN defined unless stated.

1. Reset: assert CGRA_Reset for 2 cycles with random inputs and ConfigIn=1 -> out=0, context=0, ConfigOut=0. After release with no config, the first enabled edge gives out=32'h1000_0000.
2. Load and run:
   - Shift in 12'b101_011_010_001 MSB first over 12 cycles. After that, ConfigOut=1.
   - Hold CGRA_Enable=1 for 5 cycles -> out after each edge is 0x10000001, 0x10000002, 0x10000003, 0x10000005, 0x10000001.
   - context steps 1, 2, 3, 0, 1.
   - With the macro undefined, the same sequence appears combinationally with zero lag.
3. Out-of-range select: load context 0 select = 3'b111 -> out=0 on the enabled edge while context=0.
4. Reconfigure mid-run:
   - After test 2, with context=2, raise Config_Enable together with CGRA_Enable for 3 cycles -> context stays 2 and out holds.
   - ConfigOut emits the old cfg bits 11,10,9 (1, 0, 1) in those cycles.
5. Mid-run reset: pulse CGRA_Reset for 1 cycle during test 2's run -> the next cycle gives cfg=0, context=0, out=0. Subsequent enabled edges give out=0x10000000 only.
6. NUM_CONTEXTS=1, NUM_INPUTS=2 (CFG_W=1):
   - Shift in 1 -> every enabled edge gives out=in1 and context stays 0.
   - Shift in 0 -> out=in0.
